// File: rtl/pwm_m.sv
// Memory-mapped PWM generator with an Avalon-MM-style zero-wait-state slave port.
// Period and duty are shadowed so that register writes only take effect at a period wrap.
module pwm_m (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        PWM_out
);

    localparam logic [1:0] ADDR_DIVIDE  = 2'd0;
    localparam logic [1:0] ADDR_DUTY    = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    logic [31:0] r_clockDivide;
    logic [31:0] r_dutyCycle;
    logic [31:0] r_control;
    logic [31:0] r_counter;
    logic [31:0] r_periodSh;
    logic [31:0] r_dutySh;
    logic        r_enDly;

    logic        w_wrEn;
    logic        w_rdEn;
    logic [31:0] w_byteMask;
    logic [31:0] w_readMux;
    logic        w_run;
    logic        w_wrap;
    logic        w_compare;

    assign w_wrEn = chipselect & write;
    assign w_rdEn = chipselect & read;

    assign w_byteMask = {{8{byteenable[3]}}, {8{byteenable[2]}},
                         {8{byteenable[1]}}, {8{byteenable[0]}}};

    // Counter only runs once enable has been seen for a full cycle, giving a
    // clean period start; clearing enable stops it on the very next edge.
    assign w_run = r_control[0] & r_enDly;

    assign w_wrap = (r_periodSh <= 32'd1) || (r_counter >= (r_periodSh - 32'd1));

    assign w_compare = r_counter < r_dutySh;

    always_comb begin
        w_readMux = 32'd0;
        case (address)
            ADDR_DIVIDE:  w_readMux = r_clockDivide;
            ADDR_DUTY:    w_readMux = r_dutyCycle;
            ADDR_CONTROL: w_readMux = r_control;
            ADDR_STATUS:  w_readMux = r_counter;
            default:      w_readMux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clockDivide <= 32'd0;
            r_dutyCycle   <= 32'd0;
            r_control     <= 32'd0;
        end else if (w_wrEn) begin
            case (address)
                ADDR_DIVIDE:
                    r_clockDivide <= (r_clockDivide & ~w_byteMask) | (writedata & w_byteMask);
                ADDR_DUTY:
                    r_dutyCycle <= (r_dutyCycle & ~w_byteMask) | (writedata & w_byteMask);
                ADDR_CONTROL:
                    r_control <= (r_control & ~w_byteMask) | (writedata & w_byteMask);
                default: ;
            endcase
        end
    end

    // Read mux samples pre-write register values, so a colliding write is not visible yet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else if (w_rdEn) begin
            readdata <= w_readMux;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enDly    <= 1'b0;
            r_counter  <= 32'd0;
            r_periodSh <= 32'd0;
            r_dutySh   <= 32'd0;
            PWM_out    <= 1'b0;
        end else begin
            r_enDly <= r_control[0];
            if (!w_run) begin
                r_counter  <= 32'd0;
                r_periodSh <= r_clockDivide;
                r_dutySh   <= r_dutyCycle;
                PWM_out    <= 1'b0;
            end else begin
                if (w_wrap) begin
                    r_counter  <= 32'd0;
                    r_periodSh <= r_clockDivide;
                    r_dutySh   <= r_dutyCycle;
                end else begin
                    r_counter <= r_counter + 32'd1;
                end
                PWM_out <= w_compare ^ r_control[1];
            end
        end
    end

endmodule

// File: tb/tb_pwm_m.sv
// Self-checking bench for pwm_m: register map, byte enables, waveform shape
// against an arithmetic period/duty model, shadowing, disable and async reset.
module tb_pwm_m;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        chipselect = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic        read = 1'b0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] readdata;
    logic        PWM_out;

    int errorCount = 0;
    int checkCount = 0;
    logic [31:0] modelReg [0:3];

    pwm_m dut (
        .clk(clk),
        .reset_n(reset_n),
        .chipselect(chipselect),
        .address(address),
        .write(write),
        .writedata(writedata),
        .read(read),
        .byteenable(byteenable),
        .readdata(readdata),
        .PWM_out(PWM_out)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mergeBytes(logic [31:0] oldVal, logic [31:0] newVal, logic [3:0] be);
        logic [31:0] res = oldVal;
        for (int i = 0; i < 4; i++)
            if (be[i]) res[8*i +: 8] = newVal[8*i +: 8];
        return res;
    endfunction

    // Output k cycles into a steady waveform: high for the first min(duty, period)
    // cycles of every max(period, 1)-cycle period, flipped when inverted.
    function automatic logic expPwm(longint k, longint p, longint d, logic inv);
        longint pe = (p == 0) ? 1 : p;
        return ((k % pe) < d) ^ inv;
    endfunction

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = a; writedata = d; byteenable = be;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        if (a != 2'd3) modelReg[a] = mergeBytes(modelReg[a], d, be);
    endtask

    task automatic busRead(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) modelReg[i] = 32'd0;
        repeat (3) @(negedge clk);
        checkCount++;
        if (PWM_out !== 1'b0) begin
            errorCount++;
            $display("FAIL reset_pwm: got %b expected 0", PWM_out);
        end
        checkCount++;
        if (readdata !== 32'd0) begin
            errorCount++;
            $display("FAIL reset_readdata: got %h expected 00000000", readdata);
        end
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            busRead(2'(a), rd);
            checkCount++;
            if (rd !== 32'd0) begin
                errorCount++;
                $display("FAIL reset_reg%0d: got %h expected 00000000", a, rd);
            end
        end
    endtask

    task automatic test_register_access;
        logic [31:0] rd;
        busWrite(2'd0, 32'h000000FF, 4'hF);
        busRead(2'd0, rd);
        checkCount++;
        if (rd !== 32'h000000FF) begin
            errorCount++;
            $display("FAIL reg_access: got %h expected 000000ff", rd);
        end
    endtask

    task automatic test_byte_enables;
        logic [31:0] rd;
        busWrite(2'd1, 32'h12345678, 4'b1111);
        busWrite(2'd1, 32'hAABBCCDD, 4'b0101);
        busRead(2'd1, rd);
        checkCount++;
        if (rd !== 32'h12BB56DD) begin
            errorCount++;
            $display("FAIL byte_enable: got %h expected 12bb56dd", rd);
        end
    endtask

    task automatic test_random_registers;
        logic [31:0] rd;
        logic [1:0]  a;
        for (int it = 0; it < 20; it++) begin
            busWrite(2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
            a = 2'($urandom_range(0, 2));
            busRead(a, rd);
            checkCount++;
            if (rd !== modelReg[a]) begin
                errorCount++;
                $display("FAIL rand_reg it=%0d addr=%0d: got %h expected %h", it, a, rd, modelReg[a]);
            end
        end
        busWrite(2'd2, 32'd0, 4'hF);
    endtask

    task automatic test_rw_collision;
        logic [31:0] oldVal;
        logic [31:0] rd;
        oldVal = modelReg[0];
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        address = 2'd0; writedata = 32'hC0FFEE01; byteenable = 4'hF;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        modelReg[0] = 32'hC0FFEE01;
        checkCount++;
        if (readdata !== oldVal) begin
            errorCount++;
            $display("FAIL rw_collision_old: got %h expected %h", readdata, oldVal);
        end
        busRead(2'd0, rd);
        checkCount++;
        if (rd !== 32'hC0FFEE01) begin
            errorCount++;
            $display("FAIL rw_collision_new: got %h expected c0ffee01", rd);
        end
    endtask

    task automatic test_full_config;
        logic [31:0] rd;
        busWrite(2'd0, 32'd255, 4'hF);
        busWrite(2'd1, 32'h000000AA, 4'hF);
        busRead(2'd1, rd);
        checkCount++;
        if (rd !== 32'h000000AA) begin
            errorCount++;
            $display("FAIL full_duty_read: got %h expected 000000aa", rd);
        end
        busWrite(2'd2, 32'd1, 4'hF);
        @(negedge clk);
        checkCount++;
        if (PWM_out !== 1'b0) begin
            errorCount++;
            $display("FAIL full_latency: got %b expected 0", PWM_out);
        end
        for (int k = 0; k < 510; k++) begin
            @(negedge clk);
            checkCount++;
            if (PWM_out !== expPwm(k, 255, 170, 1'b0)) begin
                errorCount++;
                $display("FAIL full_wave k=%0d: got %b expected %b", k, PWM_out, expPwm(k, 255, 170, 1'b0));
            end
        end
        busRead(2'd2, rd);
        checkCount++;
        if (rd !== 32'd1) begin
            errorCount++;
            $display("FAIL full_ctrl_read: got %h expected 00000001", rd);
        end
        busWrite(2'd2, 32'd0, 4'hF);
        @(negedge clk);
        checkCount++;
        if (PWM_out !== 1'b0) begin
            errorCount++;
            $display("FAIL full_disable: got %b expected 0", PWM_out);
        end
    endtask

    task automatic test_waveforms;
        // Fixed boundary cases first, then randomized period/duty/invert.
        logic [31:0] pTab [0:4] = '{32'd10, 32'd10, 32'd10, 32'd0, 32'd1};
        logic [31:0] dTab [0:4] = '{32'd0, 32'd20, 32'd3, 32'd5, 32'd0};
        logic        iTab [0:4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] p, d;
        logic        inv;
        int          len;
        for (int c = 0; c < 9; c++) begin
            if (c < 5) begin
                p = pTab[c]; d = dTab[c]; inv = iTab[c];
            end else begin
                p = $urandom_range(0, 12); d = $urandom_range(0, 15); inv = 1'($urandom_range(0, 1));
            end
            busWrite(2'd0, p, 4'hF);
            busWrite(2'd1, d, 4'hF);
            busWrite(2'd2, {30'd0, inv, 1'b1}, 4'hF);
            @(negedge clk);
            checkCount++;
            if (PWM_out !== 1'b0) begin
                errorCount++;
                $display("FAIL wave_latency case=%0d: got %b expected 0", c, PWM_out);
            end
            len = 3 * ((p == 0) ? 1 : int'(p)) + 3;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                checkCount++;
                if (PWM_out !== expPwm(k, p, d, inv)) begin
                    errorCount++;
                    $display("FAIL wave case=%0d p=%0d d=%0d inv=%0d k=%0d: got %b expected %b",
                             c, p, d, inv, k, PWM_out, expPwm(k, p, d, inv));
                end
            end
            busWrite(2'd2, 32'd0, 4'hF);
            @(negedge clk);
            checkCount++;
            if (PWM_out !== 1'b0) begin
                errorCount++;
                $display("FAIL wave_disable case=%0d: got %b expected 0", c, PWM_out);
            end
        end
    endtask

    task automatic test_mid_update;
        logic [31:0] rd;
        logic        e;
        busWrite(2'd0, 32'd10, 4'hF);
        busWrite(2'd1, 32'd3, 4'hF);
        busWrite(2'd2, 32'd1, 4'hF);
        @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            // Duty write lands inside period 0, so only period 1 onward sees it.
            e = expPwm(k, 10, (k < 10) ? 3 : 7, 1'b0);
            checkCount++;
            if (PWM_out !== e) begin
                errorCount++;
                $display("FAIL mid_update k=%0d: got %b expected %b", k, PWM_out, e);
            end
            if (k == 4) begin
                chipselect = 1'b1; write = 1'b1; address = 2'd1;
                writedata = 32'd7; byteenable = 4'hF;
            end else if (k == 5) begin
                chipselect = 1'b0; write = 1'b0;
                modelReg[1] = 32'd7;
            end
        end
        busWrite(2'd2, 32'd0, 4'hF);
        @(negedge clk);
        checkCount++;
        if (PWM_out !== 1'b0) begin
            errorCount++;
            $display("FAIL disable_pwm: got %b expected 0", PWM_out);
        end
        busRead(2'd3, rd);
        checkCount++;
        if (rd !== 32'd0) begin
            errorCount++;
            $display("FAIL disable_status: got %h expected 00000000", rd);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] rd;
        busWrite(2'd0, 32'd10, 4'hF);
        busWrite(2'd1, 32'd5, 4'hF);
        busRead(2'd1, rd);
        checkCount++;
        if (rd !== 32'd5) begin
            errorCount++;
            $display("FAIL areset_pre_read: got %h expected 00000005", rd);
        end
        busWrite(2'd2, 32'd1, 4'hF);
        @(negedge clk);
        @(negedge clk);
        checkCount++;
        if (PWM_out !== 1'b1) begin
            errorCount++;
            $display("FAIL areset_pre_pwm: got %b expected 1", PWM_out);
        end
        #2 reset_n = 1'b0;
        #1;
        checkCount++;
        if (PWM_out !== 1'b0) begin
            errorCount++;
            $display("FAIL areset_pwm: got %b expected 0", PWM_out);
        end
        checkCount++;
        if (readdata !== 32'd0) begin
            errorCount++;
            $display("FAIL areset_readdata: got %h expected 00000000", readdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) modelReg[i] = 32'd0;
        for (int a = 0; a < 4; a++) begin
            busRead(2'(a), rd);
            checkCount++;
            if (rd !== 32'd0) begin
                errorCount++;
                $display("FAIL areset_reg%0d: got %h expected 00000000", a, rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_register_access();
        test_byte_enables();
        test_random_registers();
        test_rw_collision();
        test_full_config();
        test_waveforms();
        test_mid_update();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
